// File: rtl/cla64_seq.sv
// ============================================================================
// Module   : cla64_seq (with helper cla16)
// Brief    : 64-bit adder that reuses one 16-bit CLA over four slices, LSB first.
//            Define CLA64_SEQ_OVF_EN to add the registered signed-overflow port ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic [15:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < 4; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
  end

  // Second-level lookahead across the four 4-bit groups
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

  always_comb begin
    w_c = '0;
    for (int k = 0; k < 4; k++) begin
      w_c[4*k] = w_gc[k];
      for (int j = 1; j < 4; j++) begin
        w_c[4*k+j] = w_g[4*k+j-1] | (w_p[4*k+j-1] & w_c[4*k+j-1]);
      end
    end
  end

  assign s    = w_p ^ w_c;
  assign cout = w_gc[4];
endmodule

module cla64_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] sum,
  output logic        Cout
`ifdef CLA64_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_idx;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic        r_carry;
  logic [63:0] r_partial;
  logic [63:0] r_sum;
  logic        r_cout;
  logic [15:0] w_slice_a;
  logic [15:0] w_slice_b;
  logic [15:0] w_slice_s;
  logic        w_slice_co;
  logic [63:0] w_next_partial;

  assign w_slice_a = r_a[{r_idx, 4'b0000} +: 16];
  assign w_slice_b = r_b[{r_idx, 4'b0000} +: 16];

  cla16 u_cla16 (
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (r_carry),
    .s    (w_slice_s),
    .cout (w_slice_co)
  );

  // At idx=3 this is the complete 64-bit result, so sum loads from it directly
  always_comb begin
    w_next_partial = r_partial;
    w_next_partial[{r_idx, 4'b0000} +: 16] = w_slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_partial <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a       <= A;
            r_b       <= B;
            r_carry   <= Cin;
            r_idx     <= 2'd0;
            r_partial <= '0;
            r_state   <= RUN;
          end else begin
            r_state   <= IDLE;
          end
        end
        RUN: begin
          r_partial <= w_next_partial;
          r_carry   <= w_slice_co;
          r_idx     <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_sum   <= w_next_partial;
            r_cout  <= w_slice_co;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CLA64_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && r_idx == 2'd3) begin
      r_ovf <= (r_a[63] == r_b[63]) && (w_slice_s[15] != r_a[63]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign Cout = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_cla64_seq.sv
// ============================================================================
// Module   : tb_cla64_seq
// Brief    : Directed scoreboard bench for cla64_seq; covers ovf when CLA64_SEQ_OVF_EN is set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla64_seq;
  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        Cin   = 1'b0;
  logic [63:0] A     = '0;
  logic [63:0] B     = '0;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        Cout;
`ifdef CLA64_SEQ_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  cla64_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout)
`ifdef CLA64_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] held_s = '0;
  logic        held_c = 1'b0;
  logic        held_o = 1'b0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic ci);
    exp_t        r;
    logic [64:0] t;
    t   = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    r.s = t[63:0];
    r.c = t[64];
    r.o = (a[63] == b[63]) && (t[63] != a[63]);
    return r;
  endfunction

  task automatic chk_held(input string tag);
    chk(tag, {Cout, sum}, {held_c, held_s});
`ifdef CLA64_SEQ_OVF_EN
    chk({tag, "_ovf"}, {64'd0, ovf}, {64'd0, held_o});
`endif
  endtask

  // Called at a negedge; returns at a negedge. chain leaves the DUT in DONE for a follow-on start.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                        input bit chain, input bit inject);
    exp_t e;
    start = 1'b1; A = a; B = b; Cin = ci;
    q.push_back(model(a, b, ci));
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; Cin = ~ci;
    chk("busy_e0", {64'd0, busy}, 65'd1);
    chk("done_e0", {64'd0, done}, 65'd0);
    for (int k = 1; k <= 4; k++) begin
      if (inject && k == 2) begin
        start = 1'b1; A = 64'h1; B = 64'h1; Cin = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < 4) begin
        chk("busy_run", {64'd0, busy}, 65'd1);
        chk("done_run", {64'd0, done}, 65'd0);
        chk_held("sum_hidden");
      end else begin
        chk("done_e4", {64'd0, done}, 65'd1);
        chk("busy_e4", {64'd0, busy}, 65'd0);
        if (q.size() != 0) begin
          e = q.pop_front();
          held_s = e.s; held_c = e.c; held_o = e.o;
          chk_held("result");
        end else begin
          chk("sb_depth", 65'(q.size()), 65'd1);
        end
      end
    end
    if (!chain) begin
      @(posedge clk); #1;
      chk("done_idle", {64'd0, done}, 65'd0);
      chk("busy_idle", {64'd0, busy}, 65'd0);
      chk_held("sum_kept");
    end
    @(negedge clk);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_done", {64'd0, done}, 65'd0);
    chk("rst_sum",  {1'b0, sum},   65'd0);
    chk("rst_cout", {64'd0, Cout}, 65'd0);
`ifdef CLA64_SEQ_OVF_EN
    chk("rst_ovf",  {64'd0, ovf},  65'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);

    // Abort an operation at idx=2 with a mid-cycle reset
    start = 1'b1; A = 64'h5; B = 64'h7; Cin = 1'b0;
    q.push_back(model(64'h5, 64'h7, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    q.delete();
    held_s = '0; held_c = 1'b0; held_o = 1'b0;
    chk("abort_busy", {64'd0, busy}, 65'd0);
    chk("abort_done", {64'd0, done}, 65'd0);
    chk_held("abort_sum");
    @(posedge clk); #1;
    chk("abort_nodone", {64'd0, done}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'h3C3, 64'hCF, 1'b1, 1'b0, 1'b0);

    // Full carry ripple, then a start accepted while in DONE
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b0);

    // A start raised mid-RUN must be ignored
    run_op(64'hFF00, 64'h00FF, 1'b1, 1'b0, 1'b1);

    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
